// File: rtl/mkg_pkg.sv
// mkg_pkg: shared FSM states, whitening constant and 4-bit MKG reversible cell
package mkg_pkg;
  typedef enum logic [1:0] {IDLE, MIX, DONE} state_t;
  localparam logic [7:0] WHITEN_KEY = 8'hA5;
  function automatic logic [3:0] mkg_cell(input logic [3:0] n);
    logic a, b, c, d, t;
    {a, b, c, d} = n;
    t = (~a & ~d) ^ ~b;
    return {a, c, t ^ c, (t & c) ^ ((a & b) ^ d)};
  endfunction
endpackage

// File: rtl/mkg_layer.sv
// mkg_layer: one combinational mixing layer of CW/4 MKG cells followed by rotl1
module mkg_layer
  import mkg_pkg::*;
#(
  parameter int CW = 64
) (
  input  logic [CW-1:0] d,
  output logic [CW-1:0] q
);
  logic [CW-1:0] m;
  for (genvar i = 0; i < CW / 4; i++) begin : g_cell
    assign m[4*i +: 4] = mkg_cell(d[4*i +: 4]);
  end
  assign q = {m[CW-2:0], m[CW-1]};
endmodule

// File: rtl/mkg_challenge_mixer.sv
// mkg_challenge_mixer: iterated MKG challenge mixer with valid/ready handshake; optional round-key whitening via MKG_MIX_WHITEN_EN
module mkg_challenge_mixer
  import mkg_pkg::*;
#(
  parameter int CW     = 64,
  parameter int ROUNDS = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_chal,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_chal,
  output logic          busy
);
  localparam int CNTW = $clog2(ROUNDS + 1);
  state_t state, state_nx;
  logic [CW-1:0] state_reg, mix_in, mix_out;
  logic [CNTW-1:0] cnt;
  logic last;
`ifdef MKG_MIX_WHITEN_EN
  logic [7:0] key_byte;
  logic [CW-1:0] key;
  always_comb begin
    key_byte = WHITEN_KEY ^ 8'(cnt);
    for (int b = 0; b < CW; b++) key[b] = key_byte[b % 8];
  end
  assign mix_in = state_reg ^ key;
`else
  assign mix_in = state_reg;
`endif
  mkg_layer #(.CW(CW)) u_layer (.d(mix_in), .q(mix_out));
  assign last = cnt == CNTW'(ROUNDS - 1);
  always_comb begin
    state_nx = (state == IDLE) ? (in_valid ? MIX : IDLE) :
               (state == MIX)  ? (last ? DONE : MIX) :
                                 (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      state_reg <= '0;
      cnt       <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        state_reg <= in_chal;
        cnt       <= '0;
      end else if (state == MIX) begin
        state_reg <= mix_out;
        cnt       <= cnt + CNTW'(1);
      end
    end
  end
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state == MIX;
  assign out_chal  = state_reg;
endmodule
